time_set_ctrl: RTL and testbench

//  Button-driven BCD time-entry controller; the load side of the watch counter. Captures the watch's current digits.
//  The user edits them digit by digit (HH:MM, 24 h). Edited values are driven on *_init outputs with a 1-cycle load pulse.
//  The load pulse makes the watch reload them. Also drives the digit-select and blink indication for the display mux.

---
 rtl/time_set_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven BCD HH:MM (24 h) time-entry controller.
// It captures the watch's current digits and lets the user edit them one digit at a time.
// The edited digits are presented on *_init together with a one-cycle load pulse.
// Each raw button is synchronized and debounced, and a rising edge of the debounced level is a press.
// Optional build macro TIME_SET_AUTOREPEAT_EN: while inc is held during editing,
// an extra inc press is generated every REPEAT_CYCLES cycles.
module time_set_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_W         = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       load,
  output logic       editing,
  output logic [1:0] digit_sel,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_HD,
    S_EDIT_HO,
    S_EDIT_MD,
    S_EDIT_MO,
    S_COMMIT
  } state_t;

  localparam int B_MODE = 0;
  localparam int B_INC  = 1;
  localparam int B_OK   = 2;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;
  localparam int RP_W = (REPEAT_CYCLES   > 1) ? $clog2(REPEAT_CYCLES)   : 1;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic [2:0]                  btn_raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0][DB_W-1:0]        db_cnt;
  logic [2:0]                  db_level;
  logic [2:0]                  press;
  logic [RP_W-1:0]             rep_cnt;
  logic                        rep_press;
  logic                        ok_evt, mode_evt, inc_evt, any_evt;

  state_t             state;
  logic [3:0]         hd_q, ho_q, md_q, mo_q;
  logic [3:0]         cap_hd, cap_ho, cap_md, cap_mo;
  logic [TO_W-1:0]    to_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  assign btn_raw = {btn_ok, btn_inc, btn_mode};

  // Synchronize and debounce each button; emit a one-cycle press on a debounced rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these per-button flop arrays are control state, so they are reset like any register; only true RAM arrays are left unreset.
      sync_q   <= '0;
      db_cnt   <= '0;
      db_level <= '0;
      press    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, matching the hardware.
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
        press[i]  <= 1'b0;
        if (sync_q[i][SYNC_STAGES-1] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i]   <= '0;
          db_level[i] <= ~db_level[i];
          press[i]    <= ~db_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Auto-repeat timer: restarts on each real inc press and runs while debounced inc is held during editing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_press <= 1'b0;
    end else begin
      rep_press <= 1'b0;
      if (press[B_INC] || !db_level[B_INC] || !editing) begin
        rep_cnt <= '0;
      end else if (rep_cnt == RP_W'(REPEAT_CYCLES - 1)) begin
        rep_cnt   <= '0;
        rep_press <= AUTOREPEAT;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // Same-cycle presses resolve as ok > mode > inc; dropped presses still count as activity
  assign ok_evt   = press[B_OK];
  assign mode_evt = press[B_MODE] & ~press[B_OK];
  assign inc_evt  = (press[B_INC] | rep_press) & ~press[B_OK] & ~press[B_MODE];
  assign any_evt  = (|press) | rep_press;

  // Sanitize the watch's digits on capture so the edit registers always hold a legal time
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cap_hd = hourdec_now;
    cap_ho = hourone_now;
    cap_md = mindec_now;
    cap_mo = minone_now;
    if (hourdec_now > 4'd2) cap_hd = 4'd0;
    if (cap_hd == 4'd2 && hourone_now > 4'd3) cap_ho = 4'd3;
    else if (hourone_now > 4'd9)              cap_ho = 4'd0;
    if (mindec_now > 4'd5) cap_md = 4'd0;
    if (minone_now > 4'd9) cap_mo = 4'd0;
  end

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max_v);
    return (v >= max_v) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic state_t next_edit(input state_t s);
    case (s)
      S_EDIT_HD: return S_EDIT_HO;
      S_EDIT_HO: return S_EDIT_MD;
      S_EDIT_MD: return S_EDIT_MO;
      default:   return S_EDIT_HD;
    endcase
  endfunction

  // Edit FSM: state, edit digits, timeout, blink phase and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      hd_q         <= '0;
      ho_q         <= '0;
      md_q         <= '0;
      mo_q         <= '0;
      hourdec_init <= '0;
      hourone_init <= '0;
      mindec_init  <= '0;
      minone_init  <= '0;
      load         <= 1'b0;
      editing      <= 1'b0;
      digit_sel    <= '0;
      to_cnt       <= '0;
      blink_cnt    <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        S_IDLE: begin
          to_cnt    <= '0;
          blink_cnt <= '0;
          if (mode_evt) begin
            hd_q      <= cap_hd;
            ho_q      <= cap_ho;
            md_q      <= cap_md;
            mo_q      <= cap_mo;
            state     <= S_EDIT_HD;
            editing   <= 1'b1;
            digit_sel <= 2'd3;
          end
        end

        S_COMMIT: begin
          state <= S_IDLE;
        end

        default: begin
          blink_cnt <= blink_cnt + 1'b1;
          to_cnt    <= any_evt ? '0 : to_cnt + 1'b1;
          if (ok_evt) begin
            state        <= S_COMMIT;
            load         <= 1'b1;
            hourdec_init <= hd_q;
            hourone_init <= ho_q;
            mindec_init  <= md_q;
            minone_init  <= mo_q;
            editing      <= 1'b0;
            blink_cnt    <= '0;
          end else if (mode_evt) begin
            state     <= next_edit(state);
            digit_sel <= digit_sel - 2'd1;
            blink_cnt <= '0;
          end else if (inc_evt) begin
            case (state)
              S_EDIT_HD: begin
                hd_q <= wrap_inc(hd_q, 4'd2);
                // Moving to the 20s forces the hour-ones digit into 0..3
                if (hd_q == 4'd1 && ho_q > 4'd3) ho_q <= 4'd3;
              end
              S_EDIT_HO: ho_q <= wrap_inc(ho_q, (hd_q == 4'd2) ? 4'd3 : 4'd9);
              S_EDIT_MD: md_q <= wrap_inc(md_q, 4'd5);
              S_EDIT_MO: mo_q <= wrap_inc(mo_q, 4'd9);
              default: ;
            endcase
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_IDLE;
            editing   <= 1'b0;
            blink_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign blink = blink_cnt[BLINK_W-1];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed scenarios plus randomized edit sessions.
// A time-level reference model predicts each committed time into a queue.
// A monitor pops one expected time per observed load pulse.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 64;
  localparam int RPT = 8;
  localparam int BLW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc, btn_ok;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
  logic       load, editing, blink;
  logic [1:0] digit_sel;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_W        (BLW),
    .TIMEOUT_CYCLES (TMO),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_ok      (btn_ok),
    .hourdec_now (hourdec_now),
    .hourone_now (hourone_now),
    .mindec_now  (mindec_now),
    .minone_now  (minone_now),
    .hourdec_init(hourdec_init),
    .hourone_init(hourone_init),
    .mindec_init (mindec_init),
    .minone_init (minone_init),
    .load        (load),
    .editing     (editing),
    .digit_sel   (digit_sel),
    .blink       (blink)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          loads_seen = 0;
  logic        load_prev = 1'b0;
  logic [15:0] sb_q[$];

  // Reference model: digits indexed by digit_sel code (0=minone 1=mindec 2=hourone 3=hourdec)
  int          d[4];
  int          sel;
  bit          in_edit;
  logic [15:0] last_init;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word();
    return {hourdec_init, hourone_init, mindec_init, minone_init};
  endfunction

  function automatic logic [15:0] model_word();
    return 16'((d[3] << 12) | (d[2] << 8) | (d[1] << 4) | d[0]);
  endfunction

  function automatic int max_of(int s);
    case (s)
      3:       return 2;
      2:       return (d[3] == 2) ? 3 : 9;
      1:       return 5;
      default: return 9;
    endcase
  endfunction

  function automatic void model_capture();
    d[3] = (int'(hourdec_now) > 2) ? 0 : int'(hourdec_now);
    d[2] = int'(hourone_now);
    if (d[3] == 2 && d[2] > 3) d[2] = 3;
    d[1] = (int'(mindec_now) > 5) ? 0 : int'(mindec_now);
    d[0] = (int'(minone_now) > 9) ? 0 : int'(minone_now);
  endfunction

  function automatic void model_inc();
    d[sel] = (d[sel] >= max_of(sel)) ? 0 : d[sel] + 1;
    if (d[3] == 2 && d[2] > 3) d[2] = 3;
  endfunction

  // Monitor: every load pulse must match the oldest predicted commit and last one cycle
  always @(negedge clk) begin
    if (load) begin
      loads_seen++;
      check("load_width", 32'(load_prev), 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_load: got init %0h expected no load at %0t", init_word(), $time);
      end else begin
        check("commit_init", 32'(init_word()), 32'(sb_q.pop_front()));
      end
    end
    load_prev = load;
  end

  task automatic press(input bit m, input bit i, input bit o, input int hold);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    btn_ok   = o;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_ok   = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic do_mode();
    press(1'b1, 1'b0, 1'b0, DEB + 4);
    if (!in_edit) begin
      model_capture();
      sel     = 3;
      in_edit = 1'b1;
    end else begin
      sel = (sel == 0) ? 3 : sel - 1;
    end
    check("editing_on", 32'(editing), 32'd1);
    check("digit_sel", 32'(digit_sel), 32'(sel));
  endtask

  task automatic do_inc();
    press(1'b0, 1'b1, 1'b0, DEB + 4);
    if (in_edit) model_inc();
    check("editing_inc", 32'(editing), 32'(in_edit));
  endtask

  task automatic do_ok(input bit with_inc);
    if (in_edit) begin
      last_init = model_word();
      sb_q.push_back(last_init);
    end
    press(1'b0, with_inc, 1'b1, DEB + 4);
    in_edit = 1'b0;
    check("editing_off", 32'(editing), 32'd0);
    check("init_hold", 32'(init_word()), 32'(last_init));
    check("load_seen", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic set_now(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    hourdec_now = a;
    hourone_now = b;
    mindec_now  = c;
    minone_now  = e;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_reps;
    int n_before;
    int nops;
    bit saw0, saw1;

    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_ok = 1'b0;
    set_now(4'd0, 4'd0, 4'd0, 4'd0);
    in_edit = 1'b0;
    sel = 3;
    last_init = '0;
    repeat (3) @(negedge clk);
    check("rst_init", 32'(init_word()), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_editing", 32'(editing), 32'd0);
    check("rst_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Glitch shorter than the debounce window must not enter edit
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btn_mode = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    check("glitch_editing", 32'(editing), 32'd0);

    // Clean capture and commit of 19:59
    set_now(4'd1, 4'd9, 4'd5, 4'd9);
    do_mode();
    do_ok(1'b0);

    // Reset in the middle of an edit returns everything to zero at once
    do_mode();
    do_inc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_init", 32'(init_word()), 32'd0);
    check("midrst_editing", 32'(editing), 32'd0);
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_blink", 32'(blink), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_edit = 1'b0;
    last_init = '0;
    repeat (30) @(negedge clk);
    check("postrst_editing", 32'(editing), 32'd0);
    check("postrst_init", 32'(init_word()), 32'd0);

    // Hours clamp (17 -> 2x forces 23) then hour-tens wrap
    set_now(4'd1, 4'd7, 4'd0, 4'd0);
    do_mode();
    do_inc();
    do_inc();
    do_ok(1'b0);

    // Digit walk and per-digit wraps without carry
    set_now(4'd0, 4'd0, 4'd0, 4'd0);
    do_mode();
    repeat (3) do_mode();
    repeat (10) do_inc();
    repeat (3) do_mode();
    repeat (6) do_inc();
    do_ok(1'b0);

    // ok and inc in the same cycle: commit wins, no increment
    set_now(4'd0, 4'd4, 4'd2, 4'd1);
    do_mode();
    do_inc();
    do_ok(1'b1);

    // Inactivity timeout: no load, outputs unchanged, blink runs while editing
    set_now(4'd2, 4'd2, 4'd3, 4'd3);
    do_mode();
    n_before = loads_seen;
    saw0 = 1'b0;
    saw1 = 1'b0;
    repeat (3 * (1 << BLW)) begin
      @(negedge clk);
      if (editing) begin
        if (blink) saw1 = 1'b1;
        else saw0 = 1'b1;
      end
    end
    check("blink_toggles", 32'(saw0 && saw1), 32'd1);
    repeat (TMO) @(negedge clk);
    in_edit = 1'b0;
    check("timeout_editing", 32'(editing), 32'd0);
    check("timeout_no_load", 32'(loads_seen), 32'(n_before));
    check("timeout_init", 32'(init_word()), 32'(last_init));
    check("timeout_blink", 32'(blink), 32'd0);

    // Held inc: auto-repeat count depends on the build
`ifdef TIME_SET_AUTOREPEAT_EN
    exp_reps = 4;
`else
    exp_reps = 1;
`endif
    set_now(4'd0, 4'd0, 4'd0, 4'd0);
    do_mode();
    repeat (3) do_mode();
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (3 * RPT + RPT / 2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    for (int k = 0; k < exp_reps; k++) model_inc();
    do_ok(1'b0);

    // Randomized edit sessions, including out-of-range captured digits
    for (int it = 0; it < 12; it++) begin
      set_now(4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      do_mode();
      nops = $urandom_range(3, 6);
      for (int k = 0; k < nops; k++) begin
        if ($urandom_range(0, 9) < 7) do_inc();
        else do_mode();
      end
      do_ok(1'b0);
    end

    repeat (20) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
